// File: rtl/complex_sample_fifo_pkg.sv
// Shared constants and I/Q packing helpers for the complex sample FIFO.
// Samples are packed {I, Q}; the FIFO itself never looks inside a word.
package complex_sample_fifo_pkg;

    localparam int unsigned CSF_DATA_WIDTH = 32;
    localparam int unsigned CSF_ADDR_WIDTH = 9;

    localparam int unsigned IQ_I_MSB = 31;
    localparam int unsigned IQ_I_LSB = 16;
    localparam int unsigned IQ_Q_MSB = 15;
    localparam int unsigned IQ_Q_LSB = 0;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } iq_sample_t;

    function automatic logic [31:0] iq_pack(
        input logic [15:0] i,
        input logic [15:0] q
    );
        return {i, q};
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register is resettable and holds when the read port is idle.
module fifo_dp_ram
    import complex_sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CSF_DATA_WIDTH,
    parameter int ADDR_WIDTH = CSF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: storage itself is never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: output register loads only on an accepted read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/complex_sample_fifo.sv
// Single-clock FIFO for packed I/Q samples with level and sticky
// overflow/underflow diagnostics; storage maps onto block RAM.
module complex_sample_fifo
    import complex_sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CSF_DATA_WIDTH,
    parameter int ADDR_WIDTH = CSF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_level;
    logic                r_empty;
    logic                r_full;
    logic                r_ovf;
    logic                r_udf;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDR_WIDTH:0] w_wr_nxt;
    logic [ADDR_WIDTH:0] w_rd_nxt;

    assign w_wr_acc = wr_en_i & ~r_full;
    assign w_rd_acc = rd_en_i & ~r_empty;
    assign w_wr_nxt = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    assign w_rd_nxt = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};

    // Pointers, flags and level all advance from the post-accept pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_wr_nxt - w_rd_nxt;
            r_empty  <= (w_wr_nxt == w_rd_nxt);
            r_full   <= (w_wr_nxt[ADDR_WIDTH-1:0]
                         == w_rd_nxt[ADDR_WIDTH-1:0])
                      & (w_wr_nxt[ADDR_WIDTH]
                         != w_rd_nxt[ADDR_WIDTH]);
            r_ovf    <= r_ovf | (wr_en_i & r_full);
            r_udf    <= r_udf | (rd_en_i & r_empty);
        end
    end

    fifo_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_wr_acc & ~rst_i),
        .waddr_i (r_wr_ptr[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data_i),
        .re_i    (w_rd_acc & ~rst_i),
        .raddr_i (r_rd_ptr[ADDR_WIDTH-1:0]),
        .rdata_o (rd_data_o)
    );

    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign level_o     = r_level;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_udf;

endmodule

// File: tb/tb_complex_sample_fifo.sv
// Bench for complex_sample_fifo: vector table, queue scoreboard
// and hand-written sequences for full/empty/wrap/reset corners.
module tb_complex_sample_fifo;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] d;
        int          lvl;
        logic [31:0] rdv;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic          udf;

    int            n_vec = 0;
    int            n_err = 0;

    logic [31:0]   m_q[$];
    logic [31:0]   m_rd = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    vec_t          tbl[10];
    logic [31:0]   held;

    complex_sample_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .overflow_o  (ovf),
        .underflow_o (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("level", 32'(level), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("rd_data", rd_data, m_rd);
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("underflow", 32'(udf), 32'(m_udf));
    endtask

    task automatic cyc(input logic w, input logic r,
                       input logic [31:0] d);
        bit aw;
        bit ar;
        aw = w && (m_q.size() < DEPTH);
        ar = r && (m_q.size() > 0);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        if (ar) m_rd = m_q.pop_front();
        if (aw) m_q.push_back(d);
        if (w && !aw) m_ovf = 1'b1;
        if (r && !ar) m_udf = 1'b1;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_model();
    endtask

    task automatic do_reset(input logic w);
        rst     = 1'b1;
        wr_en   = w;
        wr_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        m_q.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_udf", 32'(udf), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            tbl[i] = '{1'b1, 1'b0, 32'(i + 1), i + 1, 32'd0};
        end
        for (int i = 0; i < 5; i++) begin
            tbl[5 + i] = '{1'b0, 1'b1, 32'd0, 4 - i, 32'(i + 1)};
        end

        do_reset(1'b0);
        repeat (2) cyc(1'b0, 1'b0, '0);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
            if (tbl[i].rd) chk("tbl_rd", rd_data, tbl[i].rdv);
        end
        chk("tbl_empty", 32'(empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, $urandom());
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd512);
        cyc(1'b1, 1'b0, 32'hFFFF_0000);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd512);
        cyc(1'b1, 1'b1, 32'h1234_5678);
        chk("full_rw_level", 32'(level), 32'd511);
        for (int i = 0; i < DEPTH - 1; i++) begin
            cyc(1'b0, 1'b1, '0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        held = rd_data;
        cyc(1'b0, 1'b1, '0);
        chk("udf_set", 32'(udf), 32'd1);
        chk("udf_hold", rd_data, held);
        cyc(1'b1, 1'b1, 32'hA5A5_0001);
        chk("empty_rw_level", 32'(level), 32'd1);
        chk("empty_rw_hold", rd_data, held);

        cyc(1'b1, 1'b0, 32'hA5A5_0002);
        cyc(1'b1, 1'b0, 32'hA5A5_0003);
        for (int i = 0; i < 1100; i++) begin
            cyc(1'b1, 1'b1, $urandom());
        end
        chk("wrap_level", 32'(level), 32'd3);

        while (m_q.size() < 100) cyc(1'b1, 1'b0, $urandom());
        chk("pre_rst_level", 32'(level), 32'd100);
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 32'hC0DE_0001);
        chk("post_rst_level", 32'(level), 32'd1);
        cyc(1'b0, 1'b1, '0);
        chk("post_rst_rd", rd_data, 32'hC0DE_0001);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
